// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency word memory between instruction fetch
// and the memory stage: alternating arbitration, backend sequencing, stalls and dump.
module mem_port_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_err,
    output logic        dm_stall,
    input  logic        halt,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_dump,
    output logic        busy
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] CNT_INIT    = 4'(LATENCY - 1);
    localparam logic       GRANT_FETCH = 1'b0;
    localparam logic       GRANT_DATA  = 1'b1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_dm_q, gnt_dm_d;
    logic        dump_done_q, dump_done_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] dm_rdata_q, dm_rdata_d;
    logic        if_done_q, if_done_d;
    logic        if_err_q, if_err_d;
    logic        dm_done_q, dm_done_d;
    logic        dm_err_q, dm_err_d;
    logic        mem_dump_q, mem_dump_d;
    logic        busy_q, busy_d;

    logic        if_pend, dm_pend, grant_dm, grant_if;
    logic [15:0] gnt_addr;

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_done   = dm_done_q;
    assign dm_err    = dm_err_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_dump  = mem_dump_q;
    assign busy      = busy_q;
    assign if_stall  = if_req & ~if_done_q;
    assign dm_stall  = dm_req & ~dm_done_q;

    always_comb begin
        // A requester still holds req during its done cycle; that is not a new request.
        if_pend  = if_req & ~if_done_q;
        dm_pend  = dm_req & ~dm_done_q;
        grant_dm = dm_pend & (~if_pend | (last_grant_q == GRANT_FETCH));
        grant_if = if_pend & ~grant_dm;
        gnt_addr = grant_dm ? dm_addr : if_addr;

        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_dm_d     = gnt_dm_q;
        dump_done_d  = dump_done_q;
        mem_en_d     = mem_en_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        if_done_d    = 1'b0;
        if_err_d     = 1'b0;
        dm_done_d    = 1'b0;
        dm_err_d     = 1'b0;
        mem_dump_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_dm || grant_if) begin
                    last_grant_d = grant_dm ? GRANT_DATA : GRANT_FETCH;
                    gnt_dm_d     = grant_dm;
                    if (gnt_addr[0]) begin
                        if_done_d = grant_if;
                        if_err_d  = grant_if;
                        dm_done_d = grant_dm;
                        dm_err_d  = grant_dm;
                    end else begin
                        state_d     = BUSY;
                        cnt_d       = CNT_INIT;
                        mem_en_d    = 1'b1;
                        mem_wr_d    = grant_dm & dm_wr;
                        mem_addr_d  = gnt_addr;
                        mem_wdata_d = grant_dm ? dm_wdata : 16'h0000;
                    end
                end else if (halt && !dump_done_q) begin
                    mem_dump_d  = 1'b1;
                    dump_done_d = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_wr_d = 1'b0;
                    if (gnt_dm_q) begin
                        dm_done_d = 1'b1;
                        if (!mem_wr_q) dm_rdata_d = mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
        busy_d = (state_d == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= GRANT_FETCH;
            gnt_dm_q     <= 1'b0;
            dump_done_q  <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            if_rdata_q   <= 16'h0000;
            dm_rdata_q   <= 16'h0000;
            if_done_q    <= 1'b0;
            if_err_q     <= 1'b0;
            dm_done_q    <= 1'b0;
            dm_err_q     <= 1'b0;
            mem_dump_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_dm_q     <= gnt_dm_d;
            dump_done_q  <= dump_done_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_done_q    <= if_done_d;
            if_err_q     <= if_err_d;
            dm_done_q    <= dm_done_d;
            dm_err_q     <= dm_err_d;
            mem_dump_q   <= mem_dump_d;
            busy_q       <= busy_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized accesses checked
// against a transaction-level model (grant order, completion cycles, shadow memory).
module tb_mem_port_arbiter;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done, if_err, if_stall;
    logic        dm_req, dm_wr;
    logic [15:0] dm_addr, dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done, dm_err, dm_stall;
    logic        halt;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_dump, busy;

    mem_port_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .if_err(if_err), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err), .dm_stall(dm_stall),
        .halt(halt), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_dump(mem_dump), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503) ^ 16'h5A5A);
    endfunction

    // Backend stub: word array, read data driven only while enabled.
    logic [15:0] mem_arr [256];
    bit          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else if (mem_en && mem_wr) begin
            mem_arr[mem_addr[8:1]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_en ? mem_arr[mem_addr[8:1]] : 16'hDEAD;

    // Reference model state
    logic [15:0] shadow [256];
    logic        last_grant_m;   // 0 = fetch, 1 = data
    logic [15:0] if_rdata_m, dm_rdata_m;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        last_grant_m = 1'b0;
        if_rdata_m   = 16'h0000;
        dm_rdata_m   = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; halt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One or two simultaneous requests, held until their own done pulse.
    task automatic do_access(input bit use_if, input logic [15:0] ia, input bit use_dm,
                             input bit dwr, input logic [15:0] da, input logic [15:0] dwd);
        bit          both, dm_first, mis_f, mis_s, wr_f, wr_s, en_f, en_s;
        logic [15:0] a_f, a_s, wd_f, wd_s;
        int          g_f, d_f, g_s, d_s, k_if, k_dm, kmax;
        both     = use_if && use_dm;
        dm_first = use_dm && (!use_if || last_grant_m == 1'b0);
        a_f  = dm_first ? da : ia;   wr_f = dm_first && dwr;   wd_f = dm_first ? dwd : 16'h0;
        a_s  = dm_first ? ia : da;   wr_s = !dm_first && dwr;  wd_s = dm_first ? 16'h0 : dwd;
        mis_f = a_f[0];
        mis_s = a_s[0];
        g_f  = 1;
        d_f  = g_f + (mis_f ? 0 : LAT);
        g_s  = d_f + 1;
        d_s  = g_s + (mis_s ? 0 : LAT);
        k_dm = !use_dm ? -1 : (dm_first ? d_f : d_s);
        k_if = !use_if ? -1 : (dm_first ? d_s : d_f);
        kmax = both ? d_s : d_f;
        last_grant_m = both ? !dm_first : dm_first;

        @(negedge clk);
        if_req = use_if; if_addr = ia;
        dm_req = use_dm; dm_wr = dwr; dm_addr = da; dm_wdata = dwd;
        #1;
        chk("if_stall_t0", if_stall, use_if);
        chk("dm_stall_t0", dm_stall, use_dm);
        for (int k = 1; k <= kmax + 1; k++) begin
            tick();
            en_f = !mis_f && k >= g_f && k < g_f + LAT;
            en_s = both && !mis_s && k >= g_s && k < g_s + LAT;
            chk("mem_en", mem_en, en_f || en_s);
            chk("busy", busy, en_f || en_s);
            if (en_f) begin
                chk("mem_addr", mem_addr, a_f);
                chk("mem_wr", mem_wr, wr_f);
                if (wr_f) chk("mem_wdata", mem_wdata, wd_f);
            end
            if (en_s) begin
                chk("mem_addr2", mem_addr, a_s);
                chk("mem_wr2", mem_wr, wr_s);
                if (wr_s) chk("mem_wdata2", mem_wdata, wd_s);
            end
            chk("mem_dump", mem_dump, 1'b0);
            chk("if_done", if_done, k == k_if);
            chk("dm_done", dm_done, k == k_dm);
            chk("if_stall", if_stall, if_req && k != k_if);
            chk("dm_stall", dm_stall, dm_req && k != k_dm);
            if (k == k_if) begin
                chk("if_err", if_err, ia[0]);
                if (!ia[0]) if_rdata_m = shadow[ia[8:1]];
            end
            if (k == k_dm) begin
                chk("dm_err", dm_err, da[0]);
                if (!da[0]) begin
                    if (dwr) shadow[da[8:1]] = dwd;
                    else     dm_rdata_m = shadow[da[8:1]];
                end
            end
            chk("if_rdata", if_rdata, if_rdata_m);
            chk("dm_rdata", dm_rdata, dm_rdata_m);
            if (k == k_if) if_req = 1'b0;
            if (k == k_dm) dm_req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        rst = 1'b1; if_req = 1'b0; if_addr = 16'h0; dm_req = 1'b0; dm_wr = 1'b0;
        dm_addr = 16'h0; dm_wdata = 16'h0; halt = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_if_done", if_done, 1'b0);
        chk("rst_dm_done", dm_done, 1'b0);
        chk("rst_if_err", if_err, 1'b0);
        chk("rst_dm_err", dm_err, 1'b0);
        chk("rst_if_rdata", if_rdata, 16'h0);
        chk("rst_dm_rdata", dm_rdata, 16'h0);
        chk("rst_mem_dump", mem_dump, 1'b0);
        rst = 1'b0;

        // Write, read back, misaligned
        do_access(1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        do_access(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
        chk("readback_beef", dm_rdata, 16'hBEEF);
        do_access(1'b0, 16'h0, 1'b1, 1'b0, 16'h0011, 16'h0);
        do_access(1'b1, 16'h0101, 1'b0, 1'b0, 16'h0, 16'h0);

        // Both requests held continuously: D,F,D,F,... one done every LAT+1 cycles
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0000;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("alt_dm_done", dm_done, (k % 10) == 5);
            chk("alt_if_done", if_done, (k % 10) == 0);
            chk("alt_mem_en", mem_en, (k % 5) != 0);
            if ((k % 10) >= 1 && (k % 10) <= 4) chk("alt_addr_dm", mem_addr, 16'h0100);
            if ((k % 10) >= 6) chk("alt_addr_if", mem_addr, 16'h0000);
            chk("alt_if_stall", if_stall, (k % 10) != 0);
            chk("alt_dm_stall", dm_stall, (k % 10) != 5);
            if ((k % 10) == 5) dm_rdata_m = shadow[8'h80];
            if ((k % 10) == 0) if_rdata_m = shadow[8'h00];
            chk("alt_if_rdata", if_rdata, if_rdata_m);
            chk("alt_dm_rdata", dm_rdata, dm_rdata_m);
        end
        if_req = 1'b0; dm_req = 1'b0;
        last_grant_m = 1'b0;
        tick();
        chk("alt_quiet_en", mem_en, 1'b0);

        // Halt during a busy read: dump deferred, exactly one pulse
        do_reset();
        @(negedge clk);
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
        for (int k = 1; k <= 26; k++) begin
            tick();
            chk("halt_mem_en", mem_en, k <= LAT);
            chk("halt_dm_done", dm_done, k == LAT + 1);
            chk("halt_dump", mem_dump, k == LAT + 2);
            if (k == LAT + 2) chk("halt_dump_idle", busy, 1'b0);
            if (k == LAT + 1) begin
                dm_rdata_m = shadow[8'h10];
                chk("halt_rdata", dm_rdata, dm_rdata_m);
                dm_req = 1'b0;
            end
            if (k == 2) halt = 1'b1;
        end
        last_grant_m = 1'b1;
        do_access(1'b0, 16'h0, 1'b1, 1'b1, 16'h0022, 16'h7E57);
        halt = 1'b0;

        // Reset in the middle of a write
        do_reset();
        @(negedge clk);
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h1234;
        tick();
        chk("rmid_en1", mem_en, 1'b1);
        tick();
        chk("rmid_en2", mem_en, 1'b1);
        rst = 1'b1; dm_req = 1'b0;
        tick();
        chk("rmid_mem_en", mem_en, 1'b0);
        chk("rmid_mem_wr", mem_wr, 1'b0);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_done", dm_done, 1'b0);
        rst = 1'b0;
        model_reset();
        // The backend already saw enabled write cycles before the reset.
        shadow[8'h18] = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rmid_no_done", dm_done, 1'b0);
            chk("rmid_no_en", mem_en, 1'b0);
        end
        do_access(1'b1, 16'h0102, 1'b1, 1'b0, 16'h0030, 16'h0);

        // Randomized accesses
        for (int it = 0; it < 60; it++) begin
            bit          ui, ud, wr;
            logic [15:0] ia, da, wd;
            ui = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            if (!ui && !ud) ud = 1'b1;
            ia = 16'h0100 | 16'($urandom_range(0, 127) * 2);
            if ($urandom_range(0, 7) == 0) ia[0] = 1'b1;
            da = 16'($urandom_range(0, 127) * 2);
            if ($urandom_range(0, 7) == 0) da[0] = 1'b1;
            wr = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            do_access(ui, ia, ud, wr, da, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Controller that shares one single-ported, fixed-latency 16-bit word memory between instruction fetch and the memory stage.
- Arbitrates between the two requesters, sequences the backend enable, write and address lines for LATENCY cycles, and returns read data with a done pulse.
- Generates pipeline stall signals and the end-of-program memory dump request.
- Sits between the fetch/memory pipeline stages and the unified memory instance.

Parameters:
LATENCY, 4, backend access cycles per request; legal range 1..15 (4-bit down-counter).

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch read request; held until if_done
if_addr  in  16  fetch byte address
if_rdata  out  16  fetch read data; valid while if_done=1
if_done  out  1  one-cycle completion pulse for fetch
if_err  out  1  with if_done: odd address, no access performed
if_stall  out  1  if_req & ~if_done (combinational)
dm_req  in  1  data request (driven by mem_read|mem_write); held until dm_done
dm_wr  in  1  1=write, 0=read; sampled at grant
dm_addr  in  16  data byte address
dm_wdata  in  16  write data
dm_rdata  out  16  data read result; valid while dm_done=1
dm_done  out  1  one-cycle completion pulse for data
dm_err  out  1  with dm_done: odd address, no access performed
dm_stall  out  1  dm_req & ~dm_done (combinational)
halt  in  1  program halted; request a memory dump
mem_en  out  1  backend enable
mem_wr  out  1  backend write strobe
mem_addr  out  16  backend address
mem_wdata  out  16  backend write data
mem_rdata  in  16  backend read data; valid at the last enabled cycle
mem_dump  out  1  one-cycle createdump pulse
busy  out  1  1 while state=BUSY

Behaviour:
- States: IDLE and BUSY. All non-stall outputs are registered.
- Reset values:
  - State IDLE; all mem_* outputs 0; all *_done and *_err 0; rdata registers 0; busy 0.
  - last_grant=FETCH, so data wins the first tie. dump_done flag cleared; counter 0.
- Grant, in IDLE only, evaluated at edge T:
  - One request pending: grant it.
  - Both pending: grant the requester not in last_grant (alternation, no starvation).
  - On grant: latch requester id, addr, wr (forced 0 for fetch) and wdata; update last_grant; set cnt=LATENCY-1; next state BUSY.
- Misaligned address (addr[0]=1):
  - Granted normally but takes no BUSY state and asserts no mem_en.
  - done+err pulse at T+1; state stays IDLE.
- BUSY, cycles T+1..T+LATENCY:
  - mem_en=1; mem_wr, mem_addr and mem_wdata are constant from the latched values.
  - cnt decrements each cycle. At cnt==0: capture mem_rdata into the granted requester's rdata register, go to IDLE, and pulse that requester's done (err=0) at T+LATENCY+1.
  - Writes also pulse done; rdata keeps its previous value on writes.
- Request-to-done latency is LATENCY+1 cycles.
- The done cycle is IDLE, so a new grant may be taken in that same cycle. Back-to-back throughput is one access per LATENCY+1 cycles.
- Requests are never accepted in BUSY. A requester dropping req mid-access does not abort; done still pulses.
- The non-granted requester's rdata and done are unaffected by the other requester's access.
- Stall: if_stall/dm_stall are high in every cycle the request is up and its done is low, including the grant cycle.
- Halt/dump:
  - When halt=1, state IDLE, no grant this cycle and dump_done=0: pulse mem_dump for one cycle (next edge) and set dump_done.
  - If halt rises while BUSY, the dump is deferred until the access completes.
  - Pending requests take priority over the dump.
  - Only one dump per reset; halt does not block later grants.
- Reset mid-access: next edge returns to IDLE, mem_en=0, no done pulse, all flags cleared as above.

Test Plan:
1. LATENCY=4. After reset, write dm_addr=0x0010, dm_wdata=0xBEEF, grant at T -> mem_en=mem_wr=1 T+1..T+4 with addr 0x0010; dm_done at T+5; dm_stall high T..T+4.
2. Read dm_addr=0x0010 with backend returning 0xBEEF -> dm_rdata=0xBEEF with dm_done at T+5; if_done stays 0.
3. if_req and dm_req both held high from reset, addresses 0x0000/0x0100 -> grants alternate D,F,D,F; done every 5 cycles; no starvation over 8 accesses.
4. dm_addr=0x0011 -> dm_done=dm_err=1 at T+1; mem_en never asserted.
5. halt raised at T+2 of a BUSY read -> read completes with done at T+5; mem_dump pulses exactly once, after the access, with no grant that cycle; holding halt high 20 cycles gives no second pulse.
6. rst at T+2 of a BUSY access -> mem_en=0 and busy=0 next cycle; no done pulse; next tie grants data first.
